// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg -- shared definitions for the NoC routing blocks.
//   * One-hot output-port constants for the 2-D mesh directions.
//   * Bit-offset helpers for the flit header. The header is packed LSB first:
//     delta_x[XW], delta_y[YW], dest_r2[P-1], dest_r1[P-1], then payload.
// No ports (package).
// ---------------------------------------------------------------------------
package noc_pkg;

   // Mesh direction one-hots. Port 0 is always the local/up port.
   localparam logic [4:0] PORT_L = 5'b00001;
   localparam logic [4:0] PORT_E = 5'b00010;
   localparam logic [4:0] PORT_N = 5'b00100;
   localparam logic [4:0] PORT_W = 5'b01000;
   localparam logic [4:0] PORT_S = 5'b10000;

   function automatic int off_dx();
      return 0;
   endfunction

   function automatic int off_dy(input int xw);
      return xw;
   endfunction

   function automatic int off_r2(input int xw, input int yw);
      return xw + yw;
   endfunction

   function automatic int off_r1(input int xw, input int yw, input int p);
      return xw + yw + (p - 1);
   endfunction

   function automatic int off_pl(input int xw, input int yw, input int p);
      return xw + yw + 2 * (p - 1);
   endfunction

endpackage

// File: rtl/route_calc.sv
// ---------------------------------------------------------------------------
// route_calc -- purely combinational route decision for one flit.
// Ports:
//   i_flit        : head flit from the input FIFO
//   i_current_r2  : this router is a level-2 router (HIER only)
//   i_current_r1  : one-hot id of this level-1 router (HIER only)
//   i_input_port  : one-hot id of the port feeding the unit (HIER only)
//   o_port        : one-hot output port; all zeros means "drop"
//   o_flit        : flit as it must leave (MESH decrements one delta)
// Deltas are sign-magnitude: MSB is the sign, the rest is the magnitude.
// ---------------------------------------------------------------------------
module route_calc
   import noc_pkg::*;
#(
   parameter int P        = 7,
   parameter int XW       = 4,
   parameter int YW       = 4,
   parameter int FW       = 32,
   parameter     TOPOLOGY = "HIER"
) (
   input  logic [FW-1:0] i_flit,
   input  logic          i_current_r2,
   input  logic [P-2:0]  i_current_r1,
   input  logic [P-1:0]  i_input_port,
   output logic [P-1:0]  o_port,
   output logic [FW-1:0] o_flit
);

   localparam bit IS_MESH = (TOPOLOGY == "MESH");
   localparam int DX_LO   = off_dx();
   localparam int DY_LO   = off_dy(XW);
   localparam int R2_LO   = off_r2(XW, YW);
   localparam int R1_LO   = off_r1(XW, YW, P);

   logic [XW-2:0] w_xmag;
   logic          w_xsgn;
   logic [YW-2:0] w_ymag;
   logic          w_ysgn;
   logic [P-2:0]  w_dest_r2;
   logic [P-2:0]  w_dest_r1;

   assign w_xmag    = i_flit[DX_LO +: XW-1];
   assign w_xsgn    = i_flit[DX_LO + XW - 1];
   assign w_ymag    = i_flit[DY_LO +: YW-1];
   assign w_ysgn    = i_flit[DY_LO + YW - 1];
   assign w_dest_r2 = i_flit[R2_LO +: P-1];
   assign w_dest_r1 = i_flit[R1_LO +: P-1];

   always_comb begin
      o_port = '0;
      o_flit = i_flit;
      if (IS_MESH) begin
         // Dimension-order: finish X before Y; the hop just taken is
         // removed from the magnitude, the sign is kept.
         if (w_xmag != '0) begin
            o_port                 = w_xsgn ? P'(PORT_W) : P'(PORT_E);
            o_flit[DX_LO +: XW-1]  = w_xmag - (XW-1)'(1);
         end else if (w_ymag != '0) begin
            o_port                 = w_ysgn ? P'(PORT_S) : P'(PORT_N);
            o_flit[DY_LO +: YW-1]  = w_ymag - (YW-1)'(1);
         end else begin
            o_port = P'(PORT_L);
         end
      end else begin
         // Hierarchical: any remaining distance goes up; a level-2 router
         // fans out by dest_r2; a level-1 router delivers by dest_r1 when
         // the flit came from above or is addressed to this cluster.
         if ((w_xmag != '0) || (w_ymag != '0)) begin
            o_port = P'(PORT_L);
         end else if (i_current_r2) begin
            o_port = {w_dest_r2, 1'b0};
         end else if ((i_input_port == P'(PORT_L)) || (w_dest_r2 == i_current_r1)) begin
            o_port = {w_dest_r1, 1'b0};
         end else begin
            o_port = P'(PORT_L);
         end
      end
   end

endmodule

// File: rtl/route_unit.sv
// ---------------------------------------------------------------------------
// route_unit -- input FIFO + registered output stage of one router port.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   current_r2/_r1      : static router identity (HIER)
//   input_port          : static one-hot id of the feeding port
//   in_valid/in_ready/in_flit          : upstream handshake
//   out_valid/out_ready/out_flit/out_port : downstream handshake
//   err_cnt             : saturating count of dropped (unroutable) flits
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once out_valid is high the
// out_flit/out_port pair is held until the transfer completes.
// ---------------------------------------------------------------------------
module route_unit
   import noc_pkg::*;
#(
   parameter int P        = 7,
   parameter int XW       = 4,
   parameter int YW       = 4,
   parameter     TOPOLOGY = "HIER",
   parameter int DEPTH    = 4,
   parameter int FW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          current_r2,
   input  logic [P-2:0]  current_r1,
   input  logic [P-1:0]  input_port,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [FW-1:0] in_flit,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [FW-1:0] out_flit,
   output logic [P-1:0]  out_port,
   output logic [7:0]    err_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [FW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_out_valid;
   logic [FW-1:0] r_out_flit;
   logic [P-1:0]  r_out_port;
   logic [7:0]    r_err_cnt;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic [FW-1:0] w_head;
   logic [P-1:0]  w_route_port;
   logic [FW-1:0] w_route_flit;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   // Held low while in reset so nothing is accepted into a FIFO being cleared.
   assign in_ready = !w_full && !rst;
   assign w_push   = in_valid && in_ready;
   // The head leaves the FIFO whenever the stage is free or being emptied;
   // a drop also pops, it just never reaches the stage.
   assign w_pop    = !w_empty && (!r_out_valid || out_ready);
   assign w_head   = r_mem[r_rd_ptr];
   assign w_drop   = (w_route_port == '0);

   route_calc #(
      .P        (P),
      .XW       (XW),
      .YW       (YW),
      .FW       (FW),
      .TOPOLOGY (TOPOLOGY)
   ) u_route_calc (
      .i_flit       (w_head),
      .i_current_r2 (current_r2),
      .i_current_r1 (current_r1),
      .i_input_port (input_port),
      .o_port       (w_route_port),
      .o_flit       (w_route_flit)
   );

   // Storage needs no reset: occupancy is tracked by r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_flit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_flit  <= '0;
         r_out_port  <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end

         if (w_pop) begin
            if (w_drop) begin
               r_out_valid <= 1'b0;
               if (r_err_cnt != 8'hFF) begin
                  r_err_cnt <= r_err_cnt + 8'd1;
               end
            end else begin
               r_out_valid <= 1'b1;
               r_out_port  <= w_route_port;
               r_out_flit  <= w_route_flit;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_flit  = r_out_flit;
   assign out_port  = r_out_port;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_route_unit.sv
// ---------------------------------------------------------------------------
// tb_route_unit -- directed bench for route_unit, one MESH and one HIER
// instance sharing clock and reset. Expected outputs come from a routing
// model written directly from the routing rules; a single negedge process
// compares every meaningful output cycle against the expected queues.
// ---------------------------------------------------------------------------
module tb_route_unit;

   localparam int P     = 7;
   localparam int FW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   // MESH instance
   logic          m_in_valid = 1'b0;
   logic          m_in_ready;
   logic [FW-1:0] m_in_flit = '0;
   logic          m_out_valid;
   logic          m_out_ready = 1'b1;
   logic [FW-1:0] m_out_flit;
   logic [P-1:0]  m_out_port;
   logic [7:0]    m_err;

   // HIER instance
   logic          h_cur_r2 = 1'b0;
   logic [P-2:0]  h_cur_r1 = '0;
   logic [P-1:0]  h_in_port = 7'b0000010;
   logic          h_in_valid = 1'b0;
   logic          h_in_ready;
   logic [FW-1:0] h_in_flit = '0;
   logic          h_out_valid;
   logic          h_out_ready = 1'b1;
   logic [FW-1:0] h_out_flit;
   logic [P-1:0]  h_out_port;
   logic [7:0]    h_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit stress = 1'b0;
   int m_drops = 0;
   int h_drops = 0;

   logic [P+FW-1:0] m_exp_q [$];
   logic [P+FW-1:0] h_exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   route_unit #(.P(P), .XW(4), .YW(4), .TOPOLOGY("MESH"), .DEPTH(DEPTH), .FW(FW)) u_mesh (
      .clk(clk), .rst(rst), .current_r2(1'b0), .current_r1(6'b000000),
      .input_port(7'b0000001),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_flit(m_in_flit),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .out_flit(m_out_flit),
      .out_port(m_out_port), .err_cnt(m_err)
   );

   route_unit #(.P(P), .XW(4), .YW(4), .TOPOLOGY("HIER"), .DEPTH(DEPTH), .FW(FW)) u_hier (
      .clk(clk), .rst(rst), .current_r2(h_cur_r2), .current_r1(h_cur_r1),
      .input_port(h_in_port),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .in_flit(h_in_flit),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_flit(h_out_flit),
      .out_port(h_out_port), .err_cnt(h_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Header: {payload[11:0], dest_r1[5:0], dest_r2[5:0], dy[3:0], dx[3:0]}
   function automatic logic [FW-1:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                        input logic [5:0] r2, input logic [5:0] r1,
                                        input logic [11:0] pl);
      return {pl, r1, r2, dy, dx};
   endfunction

   // ---------------- routing model ----------------
   function automatic logic [P-1:0] model_port(input bit h, input logic [FW-1:0] f);
      int xm = int'(f[2:0]);
      int ym = int'(f[6:4]);
      if (!h) begin
         if (xm > 0) return f[3] ? 7'd8 : 7'd2;
         if (ym > 0) return f[7] ? 7'd16 : 7'd4;
         return 7'd1;
      end
      if (xm > 0 || ym > 0) return 7'd1;
      if (h_cur_r2) return {f[13:8], 1'b0};
      if (h_in_port == 7'd1 || f[13:8] == h_cur_r1) return {f[19:14], 1'b0};
      return 7'd1;
   endfunction

   function automatic logic [FW-1:0] model_flit(input bit h, input logic [FW-1:0] f);
      logic [FW-1:0] g = f;
      int xm = int'(f[2:0]);
      int ym = int'(f[6:4]);
      if (!h) begin
         if (xm > 0) g[2:0] = 3'(xm - 1);
         else if (ym > 0) g[6:4] = 3'(ym - 1);
      end
      return g;
   endfunction

   task automatic model_accept(input bit h, input logic [FW-1:0] f);
      logic [P-1:0] p = model_port(h, f);
      if (p == '0) begin
         if (h) h_drops = (h_drops == 255) ? 255 : h_drops + 1;
         else   m_drops = (m_drops == 255) ? 255 : m_drops + 1;
      end else begin
         if (h) h_exp_q.push_back({p, model_flit(h, f)});
         else   m_exp_q.push_back({p, model_flit(h, f)});
      end
   endtask

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input bit h, input logic [FW-1:0] f);
      bit ok = 1'b0;
      int n  = 0;
      if (h) begin h_in_valid = 1'b1; h_in_flit = f; end
      else   begin m_in_valid = 1'b1; m_in_flit = f; end
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = h ? h_in_ready : m_in_ready;
         @(posedge clk);
         n++;
      end
      check(h ? "h_push_accept" : "m_push_accept", 64'(ok), 64'd1);
      if (ok) model_accept(h, f);
      #1;
      if (h) h_in_valid = 1'b0;
      else   m_in_valid = 1'b0;
   endtask

   // Single flit with a hand-computed result pinned two edges after transfer.
   task automatic one_shot(input bit h, input logic [FW-1:0] f,
                           input logic [P-1:0] ep, input logic [FW-1:0] ef);
      push(h, f);
      @(negedge clk);
      check(h ? "h_lat1_valid" : "m_lat1_valid", 64'(h ? h_out_valid : m_out_valid), 64'd0);
      @(negedge clk);
      check(h ? "h_lat2_valid" : "m_lat2_valid", 64'(h ? h_out_valid : m_out_valid), 64'd1);
      check(h ? "h_lit_port" : "m_lit_port", 64'(h ? h_out_port : m_out_port), 64'(ep));
      check(h ? "h_lit_flit" : "m_lit_flit", 64'(h ? h_out_flit : m_out_flit), 64'(ef));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_exp_q.delete();
      h_exp_q.delete();
      m_drops = 0;
      h_drops = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (m_exp_q.size() == 0) begin
            check("m_no_spurious", 64'(m_out_valid), 64'd0);
         end else if (m_out_valid === 1'b1) begin
            check("m_port", 64'(m_out_port), 64'(m_exp_q[0][P+FW-1:FW]));
            check("m_flit", 64'(m_out_flit), 64'(m_exp_q[0][FW-1:0]));
            if (m_out_ready) void'(m_exp_q.pop_front());
         end
         if (h_exp_q.size() == 0) begin
            check("h_no_spurious", 64'(h_out_valid), 64'd0);
         end else if (h_out_valid === 1'b1) begin
            check("h_port", 64'(h_out_port), 64'(h_exp_q[0][P+FW-1:FW]));
            check("h_flit", 64'(h_out_flit), 64'(h_exp_q[0][FW-1:0]));
            if (h_out_ready) void'(h_exp_q.pop_front());
         end
      end
   end

   // Downstream stall pattern used during the mixed-traffic phase.
   always @(posedge clk) begin
      if (stress) begin
         #1;
         m_out_ready = ((cyc % 3) != 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      // -------- reset state --------
      @(posedge clk); @(negedge clk);
      check("rst_m_in_ready", 64'(m_in_ready), 64'd0);
      check("rst_m_out_valid", 64'(m_out_valid), 64'd0);
      check("rst_m_out_port", 64'(m_out_port), 64'd0);
      check("rst_m_out_flit", 64'(m_out_flit), 64'd0);
      check("rst_m_err", 64'(m_err), 64'd0);
      check("rst_h_in_ready", 64'(h_in_ready), 64'd0);
      check("rst_h_out_valid", 64'(h_out_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_m_in_ready", 64'(m_in_ready), 64'd1);
      check("post_rst_h_in_ready", 64'(h_in_ready), 64'd1);
      @(posedge clk); #1;

      // -------- MESH directed --------
      one_shot(0, mk(4'b0010, 4'b0000, 6'h00, 6'h00, 12'hABC), 7'b0000010,
               mk(4'b0001, 4'b0000, 6'h00, 6'h00, 12'hABC));
      one_shot(0, mk(4'b0000, 4'b1011, 6'h15, 6'h2A, 12'h123), 7'b0010000,
               mk(4'b0000, 4'b1010, 6'h15, 6'h2A, 12'h123));
      one_shot(0, mk(4'b0000, 4'b0000, 6'h01, 6'h02, 12'h555), 7'b0000001,
               mk(4'b0000, 4'b0000, 6'h01, 6'h02, 12'h555));
      one_shot(0, mk(4'b1011, 4'b0001, 6'h00, 6'h00, 12'hF0F), 7'b0001000,
               mk(4'b1010, 4'b0001, 6'h00, 6'h00, 12'hF0F));
      one_shot(0, mk(4'b1000, 4'b0011, 6'h3F, 6'h3F, 12'hFFF), 7'b0000100,
               mk(4'b1000, 4'b0010, 6'h3F, 6'h3F, 12'hFFF));

      // -------- HIER directed --------
      h_cur_r2 = 1'b0; h_cur_r1 = 6'b000100; h_in_port = 7'b0000010;
      one_shot(1, mk(4'b0000, 4'b0000, 6'b001000, 6'b000001, 12'h111), 7'b0000001,
               mk(4'b0000, 4'b0000, 6'b001000, 6'b000001, 12'h111));
      one_shot(1, mk(4'b0000, 4'b0000, 6'b000100, 6'b010000, 12'h222), 7'b0100000,
               mk(4'b0000, 4'b0000, 6'b000100, 6'b010000, 12'h222));
      one_shot(1, mk(4'b0001, 4'b1000, 6'b000100, 6'b010000, 12'h333), 7'b0000001,
               mk(4'b0001, 4'b1000, 6'b000100, 6'b010000, 12'h333));
      h_cur_r2 = 1'b1;
      one_shot(1, mk(4'b0000, 4'b0000, 6'b000010, 6'b100000, 12'h444), 7'b0000100,
               mk(4'b0000, 4'b0000, 6'b000010, 6'b100000, 12'h444));
      h_cur_r2 = 1'b0; h_in_port = 7'b0000001;
      one_shot(1, mk(4'b0000, 4'b0000, 6'b001000, 6'b000010, 12'h666), 7'b0000100,
               mk(4'b0000, 4'b0000, 6'b001000, 6'b000010, 12'h666));

      // -------- throughput: 8 back-to-back transfers in 8 cycles --------
      c0 = cyc;
      for (int i = 0; i < 8; i++) push(0, mk(4'(i), 4'(i + 1), 6'(i), 6'(2 * i), 12'(i * 9)));
      check("m_throughput", 64'(cyc - c0), 64'd8);
      repeat (6) @(posedge clk); #1;
      check("m_stream_drained", 64'(m_exp_q.size()), 64'd0);

      // -------- backpressure: FIFO + stage hold DEPTH+1 --------
      m_out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) push(0, mk(4'b0001, 4'(i), 6'h0A, 6'h05, 12'(100 + i)));
      @(negedge clk);
      check("m_full_in_ready", 64'(m_in_ready), 64'd0);
      check("m_full_out_valid", 64'(m_out_valid), 64'd1);
      repeat (3) @(posedge clk); #1;
      m_out_ready = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("m_bp_drained", 64'(m_exp_q.size()), 64'd0);

      // -------- mixed traffic with intermittent stalls --------
      stress = 1'b1;
      for (int i = 0; i < 20; i++) push(0, mk(4'(i), 4'(i * 5), 6'(1 << (i % 6)), 6'(i), 12'(i * 7)));
      stress = 1'b0;
      @(posedge clk); #1;
      m_out_ready = 1'b1;
      repeat (12) @(posedge clk); #1;
      check("m_stress_drained", 64'(m_exp_q.size()), 64'd0);

      // -------- reset mid-operation discards buffered flits --------
      m_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(0, mk(4'b0010, 4'b0000, 6'h00, 6'h00, 12'(i)));
      do_reset();
      m_out_ready = 1'b1;
      @(negedge clk);
      check("m_flush_valid", 64'(m_out_valid), 64'd0);
      check("m_flush_in_ready", 64'(m_in_ready), 64'd1);
      repeat (6) @(posedge clk); #1;

      // -------- HIER drops and err_cnt saturation --------
      h_cur_r2 = 1'b0; h_cur_r1 = 6'b000100; h_in_port = 7'b0000001;
      for (int i = 0; i < 10; i++) push(1, mk(4'b0000, 4'b0000, 6'b000001, 6'b000000, 12'(i)));
      repeat (3) @(posedge clk); #1;
      check("h_err_10", 64'(h_err), 64'd10);
      check("h_err_model_10", 64'(h_err), 64'(h_drops));
      for (int i = 10; i < 300; i++) push(1, mk(4'b0000, 4'b0000, 6'b000001, 6'b000000, 12'(i)));
      repeat (3) @(posedge clk); #1;
      check("h_err_sat", 64'(h_err), 64'd255);
      check("h_err_model_sat", 64'(h_err), 64'(h_drops));
      check("m_err_zero", 64'(m_err), 64'(m_drops));
      do_reset();
      @(negedge clk);
      check("h_err_after_rst", 64'(h_err), 64'd0);
      check("h_valid_after_rst", 64'(h_out_valid), 64'd0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
